// File: rtl/frame_capture_pkg.sv
// Shared types and constants for the frame capture block: reader states,
// CRC-16-CCITT constants and the default raster geometry.
package frame_capture_pkg;

  localparam int DEF_H_ACTIVE = 256;
  localparam int DEF_V_ACTIVE = 240;

  localparam logic [15:0] CRC_POLY = 16'h1021;
  localparam logic [15:0] CRC_INIT = 16'hFFFF;

  typedef enum logic [1:0] {
    R_IDLE,
    R_FETCH,
    R_STREAM
  } rd_state_t;

  // One byte of CRC-16-CCITT, MSB first.
  function automatic logic [15:0] crc16_byte(input logic [15:0] crc, input logic [7:0] data);
    logic [15:0] c;
    c = crc;
    for (int i = 7; i >= 0; i--) begin
      if (c[15] ^ data[i]) c = {c[14:0], 1'b0} ^ CRC_POLY;
      else                 c = {c[14:0], 1'b0};
    end
    return c;
  endfunction

endpackage

// File: rtl/frame_capture_ram.sv
// Simple dual-port RAM: one write port, one synchronous read port with a
// single cycle of latency. Read data holds while i_rd_en is low.
module frame_capture_ram #(
  parameter int DEPTH = 16,
  parameter int AW    = 4,
  parameter int DW    = 8
) (
  input  logic          clk,
  input  logic          i_wr_en,
  input  logic [AW-1:0] i_wr_addr,
  input  logic [DW-1:0] i_wr_data,
  input  logic          i_rd_en,
  input  logic [AW-1:0] i_rd_addr,
  output logic [DW-1:0] o_rd_data
);

  logic [DW-1:0] r_mem [DEPTH];
  logic [DW-1:0] r_rd_data;

  always_ff @(posedge clk) begin
    if (i_wr_en) r_mem[i_wr_addr] <= i_wr_data;
    if (i_rd_en) r_rd_data <= r_mem[i_rd_addr];
  end

  assign o_rd_data = r_rd_data;

endmodule

// File: rtl/frame_capture.sv
// Double-buffered PPU frame grabber with a ready/valid readout stream.
// Optional frame CRC port when FRAME_CAPTURE_CRC_EN is defined.
module frame_capture
  import frame_capture_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int PIX_W    = 6,
  localparam int ADDR_W  = $clog2(H_ACTIVE * V_ACTIVE)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ce,
  input  logic [8:0]        scanline,
  input  logic [8:0]        cycle,
  input  logic [PIX_W-1:0]  color,
  input  logic              capture_en,
  input  logic              dump_req,
`ifdef FRAME_CAPTURE_CRC_EN
  output logic [15:0]       frame_crc,
`endif
  output logic              out_valid,
  input  logic              out_ready,
  output logic [PIX_W-1:0]  out_data,
  output logic [ADDR_W-1:0] out_addr,
  output logic              out_last,
  output logic              busy,
  output logic [15:0]       frame_count,
  output logic [7:0]        drop_count
);

  localparam int NPIX = H_ACTIVE * V_ACTIVE;
  localparam logic [31:0] H_LIM = 32'(H_ACTIVE);
  localparam logic [31:0] V_LIM = 32'(V_ACTIVE);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NPIX - 1);

  // R_IDLE   | waiting for dump_req with a completed frame
  // R_FETCH  | RAM read of r_addr in flight
  // R_STREAM | beat at r_addr presented, waiting for handshake
  rd_state_t r_state, w_state_nxt;

  logic              r_wr_buf, r_rd_buf, r_frame_avail;
  logic [ADDR_W-1:0] r_addr;
  logic [15:0]       r_frame_count;
  logic [7:0]        r_drop_count;

  logic              w_pix_wr, w_frame_end, w_idle, w_start, w_hs, w_last;
  logic [ADDR_W-1:0] w_pix_addr;
  logic [PIX_W-1:0]  w_rd_data;

  assign w_pix_wr    = ce & capture_en & (32'(scanline) < V_LIM) & (32'(cycle) < H_LIM);
  assign w_pix_addr  = ADDR_W'(32'(scanline) * H_LIM + 32'(cycle));
  assign w_frame_end = w_pix_wr & (32'(scanline) == V_LIM - 1) & (32'(cycle) == H_LIM - 1);
  assign w_idle      = (r_state == R_IDLE);
  // A frame finishing in the same cycle counts as available: swap wins.
  assign w_start     = w_idle & dump_req & (r_frame_avail | w_frame_end);
  assign w_hs        = (r_state == R_STREAM) & out_ready;
  assign w_last      = (r_addr == LAST_ADDR);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      R_IDLE:   if (w_start) w_state_nxt = R_FETCH;
      R_FETCH:  w_state_nxt = R_STREAM;
      R_STREAM: if (w_hs) w_state_nxt = w_last ? R_IDLE : R_FETCH;
      default:  w_state_nxt = R_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state       <= R_IDLE;
      r_wr_buf      <= 1'b0;
      r_rd_buf      <= 1'b1;
      r_frame_avail <= 1'b0;
      r_addr        <= '0;
      r_frame_count <= '0;
      r_drop_count  <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_frame_end) begin
        r_frame_count <= r_frame_count + 16'd1;
        if (w_idle) begin
          r_wr_buf      <= ~r_wr_buf;
          r_frame_avail <= 1'b1;
        end else if (r_drop_count != 8'hFF) begin
          r_drop_count <= r_drop_count + 8'd1;
        end
      end
      if (w_start) begin
        r_rd_buf <= w_frame_end ? r_wr_buf : ~r_wr_buf;
        r_addr   <= '0;
      end else if (w_hs && !w_last) begin
        r_addr <= r_addr + 1'b1;
      end
    end
  end

  // Depth rounded up to a power of two so the buffer select is a plain address MSB.
  frame_capture_ram #(
    .DEPTH (2 << ADDR_W),
    .AW    (ADDR_W + 1),
    .DW    (PIX_W)
  ) u_ram (
    .clk       (clk),
    .i_wr_en   (w_pix_wr),
    .i_wr_addr ({r_wr_buf, w_pix_addr}),
    .i_wr_data (color),
    .i_rd_en   (r_state == R_FETCH),
    .i_rd_addr ({r_rd_buf, r_addr}),
    .o_rd_data (w_rd_data)
  );

  assign out_valid   = (r_state == R_STREAM);
  assign out_data    = out_valid ? w_rd_data : '0;
  assign out_addr    = r_addr;
  assign out_last    = out_valid & w_last;
  assign busy        = ~w_idle;
  assign frame_count = r_frame_count;
  assign drop_count  = r_drop_count;

`ifdef FRAME_CAPTURE_CRC_EN
  logic [15:0] r_crc_acc, r_frame_crc, w_crc_nxt;

  assign w_crc_nxt = crc16_byte((w_pix_addr == '0) ? CRC_INIT : r_crc_acc, 8'(color));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_crc_acc   <= CRC_INIT;
      r_frame_crc <= CRC_INIT;
    end else begin
      if (w_pix_wr)    r_crc_acc   <= w_crc_nxt;
      if (w_frame_end) r_frame_crc <= w_crc_nxt;
    end
  end

  assign frame_crc = r_frame_crc;
`endif

endmodule

// File: tb/tb_frame_capture.sv
// Directed/randomized bench for frame_capture on a 4x2 raster, checked
// against a frame-level model (published frame, counters, reader busy flag).
module tb_frame_capture;

  localparam int H  = 4;
  localparam int V  = 2;
  localparam int NP = H * V;
  localparam int PW = 6;
  localparam int AW = 3;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          ce = 1'b0;
  logic [8:0]    scanline = '0;
  logic [8:0]    cycle = '0;
  logic [PW-1:0] color = '0;
  logic          capture_en = 1'b0;
  logic          dump_req = 1'b0;
  logic          out_ready = 1'b0;
  logic          out_valid, out_last, busy;
  logic [PW-1:0] out_data;
  logic [AW-1:0] out_addr;
  logic [15:0]   frame_count;
  logic [7:0]    drop_count;
`ifdef FRAME_CAPTURE_CRC_EN
  logic [15:0]   frame_crc;
  logic [15:0]   m_crc;
`endif

  frame_capture #(.H_ACTIVE(H), .V_ACTIVE(V), .PIX_W(PW)) dut (
    .clk         (clk),
    .reset       (reset),
    .ce          (ce),
    .scanline    (scanline),
    .cycle       (cycle),
    .color       (color),
    .capture_en  (capture_en),
    .dump_req    (dump_req),
`ifdef FRAME_CAPTURE_CRC_EN
    .frame_crc   (frame_crc),
`endif
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_addr    (out_addr),
    .out_last    (out_last),
    .busy        (busy),
    .frame_count (frame_count),
    .drop_count  (drop_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Model: frame being written, last published frame, counters, reader state.
  int cur [NP];
  int pub [NP];
  bit m_avail = 0;
  bit m_busy = 0;
  int m_fc = 0;
  int m_dc = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

`ifdef FRAME_CAPTURE_CRC_EN
  function automatic logic [15:0] crc_ref();
    logic [15:0] c;
    c = 16'hFFFF;
    for (int p = 0; p < NP; p++) begin
      c = c ^ {8'(cur[p]), 8'h00};
      for (int b = 0; b < 8; b++) c = c[15] ? ((c << 1) ^ 16'h1021) : (c << 1);
    end
    return c;
  endfunction
`endif

  task automatic model_frame_end(input bit dump_same);
    m_fc = (m_fc + 1) & 16'hFFFF;
    if (!m_busy) begin
      pub = cur;
      m_avail = 1;
      if (dump_same) m_busy = 1;
    end else if (m_dc < 255) begin
      m_dc++;
    end
`ifdef FRAME_CAPTURE_CRC_EN
    m_crc = crc_ref();
`endif
  endtask

  // mode 0: color = raster address, 1: random, 2: all zero.
  task automatic cap_frame(input int mode, input bit dump_at_end);
    int col;
    for (int s = 0; s < V; s++) begin
      for (int c = 0; c < H; c++) begin
        col = (mode == 0) ? (s * H + c) : (mode == 1) ? int'($urandom_range(0, 63)) : 0;
        if ($urandom_range(0, 2) == 0) begin
          ce = 1; capture_en = 0; scanline = 9'(s); cycle = 9'(c); color = PW'($urandom);
          tick();
        end
        if ($urandom_range(0, 2) == 0) begin
          ce = 0; capture_en = 1; scanline = 9'(s); cycle = 9'(c); color = PW'($urandom);
          tick();
        end
        ce = 1; capture_en = 1; scanline = 9'(s); cycle = 9'(c); color = PW'(col);
        dump_req = dump_at_end && (s == V - 1) && (c == H - 1);
        tick();
        dump_req = 0;
        cur[s * H + c] = col;
        if (s == V - 1 && c == H - 1) model_frame_end(dump_at_end);
        if (c == H - 1) begin
          cycle = 9'(H + $urandom_range(0, 300)); color = PW'($urandom);
          tick();
        end
      end
    end
    scanline = 9'(V + $urandom_range(0, 250)); cycle = 9'($urandom_range(0, 3)); color = PW'($urandom);
    tick();
    ce = 0; capture_en = 0;
  endtask

  task automatic cap_off();
    for (int p = 0; p < NP; p++) begin
      ce = 1; capture_en = 0; scanline = 9'(p / H); cycle = 9'(p % H); color = PW'($urandom);
      tick();
    end
    ce = 0;
  endtask

  task automatic do_dump();
    dump_req = 1;
    tick();
    dump_req = 0;
    if (m_avail && !m_busy) m_busy = 1;
  endtask

  // Receive n_beats beats; every sampled valid cycle is checked, so a
  // stalled beat must stay equal to the same expected pixel.
  task automatic stream(input int n_beats, input bit rnd_ready);
    int idx;
    int budget;
    idx = 0;
    budget = 0;
    while (idx < n_beats && budget < 1000) begin
      out_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge clk);
      if (out_valid) begin
        chk("beat_data", 32'(out_data), 32'(pub[idx]));
        chk("beat_addr", 32'(out_addr), 32'(idx));
        chk("beat_last", 32'(out_last), 32'(idx == NP - 1));
        if (out_ready) idx++;
      end
      tick();
      budget++;
    end
    out_ready = 0;
    chk("stream_beats", 32'(idx), 32'(n_beats));
    if (idx == NP) m_busy = 0;
  endtask

  task automatic chk_counters(input string tag);
    chk({tag, "_frame_count"}, 32'(frame_count), 32'(m_fc));
    chk({tag, "_drop_count"}, 32'(drop_count), 32'(m_dc));
  endtask

  initial begin
    #2 reset = 0;
    repeat (2) tick();
    @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_last", 32'(out_last), 0);
    chk("rst_out_data", 32'(out_data), 0);
    chk("rst_out_addr", 32'(out_addr), 0);
    chk("rst_busy", 32'(busy), 0);
    chk_counters("rst");
`ifdef FRAME_CAPTURE_CRC_EN
    chk("rst_frame_crc", 32'(frame_crc), 32'hFFFF);
`endif
    tick();
    reset = 1;

    // dump with nothing captured is ignored
    do_dump();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("nodump_valid", 32'(out_valid), 0);
      chk("nodump_busy", 32'(busy), 0);
      tick();
    end

    // color = address frame, full-rate readout
    cap_frame(0, 0);
    chk_counters("frame0");
    do_dump();
    @(negedge clk);
    chk("fetch_busy", 32'(busy), 1);
    chk("fetch_valid", 32'(out_valid), 0);
    tick();
    stream(NP, 0);
    @(negedge clk);
    chk("idle_after_last", 32'(busy), 0);
    tick();

    // random frame, random backpressure
    cap_frame(1, 0);
    do_dump();
    stream(NP, 1);

    // stalled stream while two more frames complete
    cap_frame(1, 0);
    do_dump();
    out_ready = 0;
    repeat (2) tick();
    cap_frame(1, 0);
    cap_frame(1, 0);
    @(negedge clk);
    chk("stall_valid", 32'(out_valid), 1);
    chk("stall_data", 32'(out_data), 32'(pub[0]));
    chk("stall_addr", 32'(out_addr), 0);
    chk("drop_two", 32'(drop_count), 2);
    chk_counters("stall");
    tick();
    stream(NP, 1);

    // frame end and dump in the same cycle
    cap_frame(1, 1);
    stream(NP, 1);
    chk_counters("same_cycle");

    // reset after the third handshake
    cap_frame(1, 0);
    do_dump();
    stream(3, 0);
    reset = 0;
    #1;
    chk("midrst_valid", 32'(out_valid), 0);
    chk("midrst_busy", 32'(busy), 0);
    chk("midrst_fc", 32'(frame_count), 0);
    chk("midrst_dc", 32'(drop_count), 0);
    m_avail = 0; m_busy = 0; m_fc = 0; m_dc = 0;
`ifdef FRAME_CAPTURE_CRC_EN
    m_crc = 16'hFFFF;
`endif
    tick();
    reset = 1;
    do_dump();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("postrst_valid", 32'(out_valid), 0);
      tick();
    end
    cap_frame(1, 1);
    stream(NP, 1);
    chk_counters("postrst");

    // a frame with capture disabled changes nothing
    cap_off();
    chk_counters("capoff");
    do_dump();
    stream(NP, 0);

`ifdef FRAME_CAPTURE_CRC_EN
    cap_frame(2, 0);
    @(negedge clk);
    chk("crc_zero", 32'(frame_crc), 32'(m_crc));
    tick();
    cap_off();
    @(negedge clk);
    chk("crc_hold", 32'(frame_crc), 32'(m_crc));
    tick();
    cap_frame(1, 0);
    @(negedge clk);
    chk("crc_rand", 32'(frame_crc), 32'(m_crc));
    tick();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/frame_capture.md
FRAME_CAPTURE -- requirements
Module: frame_capture

Interface
REQ-001 SHALL have parameter H_ACTIVE, default 256, visible pixels per scanline.
REQ-002 SHALL have parameter V_ACTIVE, default 240, visible scanlines per frame.
REQ-003 SHALL have parameter PIX_W, default 6, pixel (palette index) width; ADDR_W = clog2(H_ACTIVE*V_ACTIVE), derived.
REQ-004 SHALL have ports: clk  in  1  sole clock, all logic on rising edge.
REQ-005 reset  in  1  asynchronous, active-low; asserted (0) clears all state.
REQ-006 ce  in  1  pixel clock enable; scanline  in  9  PPU scanline; cycle  in  9  PPU dot; color  in  PIX_W  pixel value.
REQ-007 capture_en  in  1  gates writes; dump_req  in  1  single-cycle request to stream last completed frame.
REQ-008 out_valid  out  1; out_ready  in  1; out_data  out  PIX_W; out_addr  out  ADDR_W; out_last  out  1  (readout stream).
REQ-009 busy  out  1  reader not idle; frame_count  out  16  completed frames; drop_count  out  8  frames not published.

Function
REQ-010 Two frame buffers of H_ACTIVE*V_ACTIVE x PIX_W; writer owns wr_buf, completed frame lives in rd_buf = ~wr_buf.
REQ-011 Pixel write when ce & capture_en & scanline<V_ACTIVE & cycle<H_ACTIVE: mem[wr_buf][scanline*H_ACTIVE+cycle] <= color; otherwise no write.
REQ-012 Frame end = qualifying write at (V_ACTIVE-1, H_ACTIVE-1); frame_count increments (wraps at 16 bits).
REQ-013 At frame end with reader idle: swap wr_buf, set frame_avail=1, effective next cycle.
REQ-014 At frame end with reader busy: no swap, drop_count increments, saturating at 255; next frame overwrites wr_buf.
REQ-015 Reader FSM states R_IDLE, R_FETCH, R_STREAM.
REQ-016 R_IDLE: dump_req & frame_avail -> R_FETCH, latch rd_buf, addr=0; dump_req without frame_avail ignored.
REQ-017 R_FETCH: one-cycle synchronous RAM read; -> R_STREAM with out_valid=1 (first beat 2 cycles after dump_req).
REQ-018 R_STREAM: out_data/out_addr/out_last held stable while out_valid & !out_ready; on handshake advance addr, next beat presented cycle after (one bubble permitted per beat, or back-to-back with prefetch; either legal, ordering mandatory).
REQ-019 out_last=1 only on addr H_ACTIVE*V_ACTIVE-1; its handshake -> R_IDLE, out_valid=0.
REQ-020 Frame end and dump_req same cycle with reader idle: swap wins; reader streams the newly completed frame.
REQ-021 busy=1 in R_FETCH and R_STREAM.

Reset
REQ-022 Reset: wr_buf=0, frame_avail=0, reader R_IDLE, out_valid=0, out_last=0, out_data=0, out_addr=0, frame_count=0, drop_count=0, busy=0; buffer contents undefined, not cleared.
REQ-023 Reset mid-stream aborts stream immediately; no further beats.

Configuration
REQ-024 Macro FRAME_CAPTURE_CRC_EN defined: adds port frame_crc out 16; CRC-16-CCITT (poly 0x1021, init 0xFFFF, MSB-first) over captured pixels zero-extended to 8 bits, raster order, restarted at pixel (0,0), frame_crc updated at frame end, reset value 0xFFFF.
REQ-025 Macro undefined: no frame_crc port, no CRC logic; all other behaviour identical.

Structure
REQ-026 Shared package frame_capture_pkg holds reader state enum, CRC polynomial/init constants, default H_ACTIVE/V_ACTIVE.
REQ-027 One sub-module frame_capture_ram: simple dual-port RAM, 1 write port, 1 synchronous read port, one-cycle latency; instantiated once with depth 2*H_ACTIVE*V_ACTIVE, buffer index as address MSB.

Verification
REQ-028 H_ACTIVE=4,V_ACTIVE=2: one frame color=addr; dump_req, out_ready=1 -> 8 beats data 0..7, out_last on addr 7, frame_count=1.
REQ-029 dump_req after reset, no frame captured -> out_valid stays 0, busy stays 0.
REQ-030 Stream in progress, out_ready held 0, two further frames complete -> drop_count=2, streamed data = first frame unchanged, out_data stable while stalled.
REQ-031 Frame end and dump_req same cycle -> streamed data equals that just-completed frame.
REQ-032 Reset asserted at beat 3 of stream -> out_valid=0 immediately, counters 0, later dump_req ignored until new frame.
REQ-033 FRAME_CAPTURE_CRC_EN: constant color=0 frame -> frame_crc matches CCITT reference model over H_ACTIVE*V_ACTIVE zero bytes; capture_en=0 frame -> frame_crc unchanged.
